// File: rtl/serpent_sbox_stage_if.sv
// Beat-level handshake bundle for the Serpent key-mix/S-box stage.
// Signal prefixes are from the stage's point of view (i_ = into the stage).
interface serpent_sbox_stage_if;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_word_0, i_word_1, i_word_2, i_word_3;
  logic [31:0] i_key_0, i_key_1, i_key_2, i_key_3;
  logic [31:0] i_key_post_0, i_key_post_1, i_key_post_2, i_key_post_3;
  logic [2:0]  i_sbox_sel;
  logic        i_last;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_word_0, o_word_1, o_word_2, o_word_3;
  logic        o_last;

  modport slave (
    input  i_valid, i_word_0, i_word_1, i_word_2, i_word_3,
           i_key_0, i_key_1, i_key_2, i_key_3,
           i_key_post_0, i_key_post_1, i_key_post_2, i_key_post_3,
           i_sbox_sel, i_last, i_ready,
    output o_ready, o_valid, o_word_0, o_word_1, o_word_2, o_word_3, o_last
  );

  modport master (
    output i_valid, i_word_0, i_word_1, i_word_2, i_word_3,
           i_key_0, i_key_1, i_key_2, i_key_3,
           i_key_post_0, i_key_post_1, i_key_post_2, i_key_post_3,
           i_sbox_sel, i_last, i_ready,
    input  o_ready, o_valid, o_word_0, o_word_1, o_word_2, o_word_3, o_last
  );
endinterface

// File: rtl/serpent_sbox_stage.sv
// Serpent round front half: subkey XOR, bitsliced S-box, optional post-key,
// registered behind a 2-entry skid so back-pressure never drops a beat.
module serpent_sbox_slice (
  input  logic [2:0] i_sel,
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);
  // Nibble n of each row is S[row][n]; S7 in the top row.
  localparam logic [7:0][63:0] SBOX = {
    64'h6539_AC47_B28E_0FD1,
    64'h0A3D_F19E_B648_5C27,
    64'h176D_8E30_C9A4_B25F,
    64'hD7E9_A452_6B0C_38F1,
    64'hE57A_421D_369C_8BF0,
    64'h25B0_4E1D_FAC3_9768,
    64'h43D6_8EB1_A509_72CF,
    64'hC907_24DE_B56A_1F83
  };

  assign o_nib = SBOX[i_sel][{i_nib, 2'b00} +: 4];
endmodule

module serpent_sbox_stage #(
  parameter int SBOX_FIXED = -1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  serpent_sbox_stage_if.slave  bus
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  typedef struct packed {
    logic [3:0][31:0] word;
    logic             last;
  } beat_t;

  localparam logic [2:0] FIX_SEL = (SBOX_FIXED < 0) ? 3'd0 : 3'(SBOX_FIXED);

  state_t           r_state, w_state_nxt;
  beat_t            r_out, r_skid, w_in;
  logic [3:0][31:0] w_x, w_y, w_post;
  logic [31:0][3:0] w_sub;
  logic [2:0]       w_sel;
  logic             w_in_xfer, w_out_xfer, w_ld_out, w_ld_skid, w_skid_to_out;

  assign w_sel  = (SBOX_FIXED < 0) ? bus.i_sbox_sel : FIX_SEL;
  assign w_x    = {bus.i_word_3 ^ bus.i_key_3, bus.i_word_2 ^ bus.i_key_2,
                   bus.i_word_1 ^ bus.i_key_1, bus.i_word_0 ^ bus.i_key_0};
  assign w_post = {bus.i_key_post_3, bus.i_key_post_2,
                   bus.i_key_post_1, bus.i_key_post_0};

  genvar j;
  generate
    for (j = 0; j < 32; j++) begin : g_slice
      serpent_sbox_slice u_slice (
        .i_sel (w_sel),
        .i_nib ({w_x[3][j], w_x[2][j], w_x[1][j], w_x[0][j]}),
        .o_nib (w_sub[j])
      );
      assign w_y[0][j] = w_sub[j][0];
      assign w_y[1][j] = w_sub[j][1];
      assign w_y[2][j] = w_sub[j][2];
      assign w_y[3][j] = w_sub[j][3];
    end
  endgenerate

  assign w_in.word = w_y ^ (bus.i_last ? w_post : '0);
  assign w_in.last = bus.i_last;

  assign bus.o_valid = (r_state != EMPTY);
  assign bus.o_ready = (r_state != FULL);
  assign w_in_xfer   = bus.i_valid & bus.o_ready;
  assign w_out_xfer  = bus.o_valid & bus.i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= EMPTY;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ld_out      = 1'b0;
    w_ld_skid     = 1'b0;
    w_skid_to_out = 1'b0;
    case (r_state)
      EMPTY: if (w_in_xfer) begin
        w_state_nxt = ONE;
        w_ld_out    = 1'b1;
      end
      ONE: begin
        if (w_in_xfer && w_out_xfer) w_ld_out = 1'b1;
        else if (w_in_xfer) begin
          w_state_nxt = FULL;
          w_ld_skid   = 1'b1;
        end else if (w_out_xfer) w_state_nxt = EMPTY;
      end
      FULL: if (w_out_xfer) begin
        w_state_nxt   = ONE;
        w_skid_to_out = 1'b1;
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  // Output register only moves on a load, so it holds under back-pressure
  // and keeps its last value while idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out  <= '0;
      r_skid <= '0;
    end else begin
      if (w_ld_out)           r_out  <= w_in;
      else if (w_skid_to_out) r_out  <= r_skid;
      if (w_ld_skid)          r_skid <= w_in;
    end
  end

  assign bus.o_word_0 = r_out.word[0];
  assign bus.o_word_1 = r_out.word[1];
  assign bus.o_word_2 = r_out.word[2];
  assign bus.o_word_3 = r_out.word[3];
  assign bus.o_last   = r_out.last;
endmodule

// File: tb/tb_serpent_sbox_stage.sv
// Directed bench for serpent_sbox_stage: table-driven S-box model plus
// hand-computed vectors, handshake/back-pressure and async reset checks.
module tb_serpent_sbox_stage;
  logic clk, rst_n;
  int   n_cmp, n_err;

  serpent_sbox_stage_if bus();

  serpent_sbox_stage dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] w, k, kp;
    logic [2:0]   sel;
    logic         last;
  } beat_t;

  int SB [8][16] = '{
    '{ 3, 8,15, 1,10, 6, 5,11,14,13, 4, 2, 7, 0, 9,12},
    '{15,12, 2, 7, 9, 0, 5,10, 1,11,14, 8, 6,13, 3, 4},
    '{ 8, 6, 7, 9, 3,12,10,15,13, 1,14, 4, 0,11, 5, 2},
    '{ 0,15,11, 8,12, 9, 6, 3,13, 1, 2, 4,10, 7, 5,14},
    '{ 1,15, 8, 3,12, 0,11, 6, 2, 5, 4,10, 9,14, 7,13},
    '{15, 5, 2,11, 4,10, 9,12, 0, 3,14, 8,13, 6, 7, 1},
    '{ 7, 2,12, 5, 8, 4, 6,11,14, 9, 1,15,13, 3,10, 0},
    '{ 1,13,15, 0,14, 8, 2,11, 7, 4,12,10, 9, 3, 5, 6}
  };

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [128:0] model(input beat_t b);
    logic [127:0] x, r;
    int           n, s;
    x = b.w ^ b.k;
    r = '0;
    for (int j = 0; j < 32; j++) begin
      n = {28'd0, x[96+j], x[64+j], x[32+j], x[j]};
      s = SB[b.sel][n];
      for (int q = 0; q < 4; q++) r[32*q+j] = s[q];
    end
    if (b.last) r = r ^ b.kp;
    return {b.last, r};
  endfunction

  function automatic beat_t mk(input logic [127:0] w, k, kp, input logic [2:0] sel, input logic last);
    beat_t b;
    b.w = w; b.k = k; b.kp = kp; b.sel = sel; b.last = last;
    return b;
  endfunction

  task automatic drive(input beat_t b, input logic v);
    bus.i_valid      = v;
    {bus.i_word_3, bus.i_word_2, bus.i_word_1, bus.i_word_0} = b.w;
    {bus.i_key_3, bus.i_key_2, bus.i_key_1, bus.i_key_0}     = b.k;
    {bus.i_key_post_3, bus.i_key_post_2, bus.i_key_post_1, bus.i_key_post_0} = b.kp;
    bus.i_sbox_sel   = b.sel;
    bus.i_last       = b.last;
  endtask

  function automatic logic [128:0] got_out();
    return {bus.o_last, bus.o_word_3, bus.o_word_2, bus.o_word_1, bus.o_word_0};
  endfunction

  localparam logic [127:0] Z = '0;
  localparam logic [31:0]  F = 32'hFFFF_FFFF;

  // Single accepted beat with i_ready=1; returns the registered result.
  task automatic one_beat(input string tag, input beat_t b, input logic [128:0] exp);
    drive(b, 1'b1);
    bus.i_ready = 1'b1;
    @(negedge clk);
    drive(b, 1'b0);
    chk({tag, "_vld"}, 128'(bus.o_valid), 128'(1'b1));
    chk({tag, "_dat"}, 128'(got_out()), 128'(exp));
    @(negedge clk);
  endtask

  beat_t a, b, c, s[8];

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0;
    bus.i_ready = 1'b0;
    drive(mk(Z, Z, Z, 3'd0, 1'b0), 1'b0);
    #12;
    chk("rst_vld",  128'(bus.o_valid), 128'(1'b0));
    chk("rst_rdy",  128'(bus.o_ready), 128'(1'b1));
    chk("rst_last", 128'(bus.o_last),  128'(1'b0));
    chk("rst_word", 128'(got_out()),   128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // n=0 -> S0=3 ; n=1 -> S1=12 ; n=1 -> S0=8 ; post-key cancels it
    one_beat("t0", mk(Z, Z, Z, 3'd0, 1'b0), {1'b0, 32'h0, 32'h0, F, F});
    one_beat("t1", mk({96'h0, F}, Z, Z, 3'd1, 1'b0), {1'b0, F, F, 32'h0, 32'h0});
    one_beat("t2", mk(Z, {96'h0, F}, Z, 3'd0, 1'b0), {1'b0, F, 96'h0});
    one_beat("t3", mk(Z, {96'h0, F}, {F, 96'h0}, 3'd0, 1'b1), {1'b1, 128'h0});
    chk("t3_idle_vld", 128'(bus.o_valid), 128'(1'b0));
    chk("t3_idle_hold", 128'(got_out()), 128'({1'b1, 128'h0}));

    // Back-pressure: A in output, B in skid, C held off
    a = mk(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, Z, Z, 3'd2, 1'b0);
    b = mk(128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0, 128'h5555_AAAA_0F0F_F0F0_3333_CCCC_FF00_00FF, Z, 3'd5, 1'b0);
    c = mk(128'h1111_2222_3333_4444_5555_6666_7777_8888, Z, 128'hA5A5_A5A5_5A5A_5A5A_0000_FFFF_1234_4321, 3'd7, 1'b1);
    bus.i_ready = 1'b0;
    drive(a, 1'b1);
    @(negedge clk);
    chk("bp_a_vld", 128'(bus.o_valid), 128'(1'b1));
    chk("bp_a_rdy", 128'(bus.o_ready), 128'(1'b1));
    chk("bp_a_dat", 128'(got_out()), 128'(model(a)));
    drive(b, 1'b1);
    @(negedge clk);
    chk("bp_full_rdy", 128'(bus.o_ready), 128'(1'b0));
    chk("bp_a_hold", 128'(got_out()), 128'(model(a)));
    drive(c, 1'b1);
    @(negedge clk);
    chk("bp_c_held_rdy", 128'(bus.o_ready), 128'(1'b0));
    chk("bp_a_hold2", 128'(got_out()), 128'(model(a)));
    bus.i_ready = 1'b1;
    @(negedge clk);
    chk("bp_b_vld", 128'(bus.o_valid), 128'(1'b1));
    chk("bp_b_rdy", 128'(bus.o_ready), 128'(1'b1));
    chk("bp_b_dat", 128'(got_out()), 128'(model(b)));
    @(negedge clk);
    drive(c, 1'b0);
    chk("bp_c_vld", 128'(bus.o_valid), 128'(1'b1));
    chk("bp_c_dat", 128'(got_out()), 128'(model(c)));
    @(negedge clk);
    chk("bp_drain_vld", 128'(bus.o_valid), 128'(1'b0));
    chk("bp_drain_hold", 128'(got_out()), 128'(model(c)));

    // Full-rate stream through all eight S-boxes
    for (int k = 0; k < 8; k++)
      s[k] = mk({32'(32'h0F1E_2D3C + k), 32'(32'hA5A5_0000 ^ k), 32'(32'h1357_9BDF << k), 32'(32'hCAFE_BABE >> k)},
                {32'(32'h9E37_79B9 * (k + 1)), 32'(32'h0000_FFFF << k), 32'(~k), 32'(32'h8000_0001 ^ (k << 8))},
                {32'(32'h5A5A_5A5A + k), 32'(32'h0), 32'(32'hF0F0_F0F0), 32'(k)}, 3'(k), (k == 7));
    bus.i_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(s[k], 1'b1);
      @(negedge clk);
      chk($sformatf("st%0d_vld", k), 128'(bus.o_valid), 128'(1'b1));
      chk($sformatf("st%0d_dat", k), 128'(got_out()), 128'(model(s[k])));
    end
    drive(s[7], 1'b0);
    @(negedge clk);
    chk("st_end_vld", 128'(bus.o_valid), 128'(1'b0));

    // Async reset while FULL
    bus.i_ready = 1'b0;
    drive(a, 1'b1);
    @(negedge clk);
    drive(b, 1'b1);
    @(negedge clk);
    chk("rf_full_rdy", 128'(bus.o_ready), 128'(1'b0));
    drive(b, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rf_vld",  128'(bus.o_valid), 128'(1'b0));
    chk("rf_rdy",  128'(bus.o_ready), 128'(1'b1));
    chk("rf_word", 128'(got_out()),   128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    one_beat("rf_next", c, model(c));
    chk("rf_after_vld", 128'(bus.o_valid), 128'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/serpent_sbox_stage.md
Name: serpent_sbox_stage

Overview:
- Pipelined key-mixing and bitslice S-box stage of the Serpent encryption round.
- Sits directly upstream of the combinational linear transform; its registered o_word_0..3 drive the linear transform inputs.
- Per beat: XOR the 128-bit state with the round subkey, apply S-box S[sel] across 32 bitslices, and optionally XOR a post-key on the final round.
- Valid/ready handshake with a 2-entry skid buffer, so back-pressure never drops or duplicates a beat.

Parameters:
- SBOX_FIXED, default -1. Value -1 selects the S-box from i_sbox_sel. A value of 0..7 hard-wires S-box S[SBOX_FIXED] and ignores i_sbox_sel.

Ports:
- i_clk  input  1  clock; all state changes on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  input beat valid.
- o_ready  output  1  stage can accept a beat.
- i_word_0..i_word_3  input  32 each  state words; i_word_0 is the LSB plane.
- i_key_0..i_key_3  input  32 each  pre-S-box round subkey.
- i_key_post_0..i_key_post_3  input  32 each  post-S-box key; used only when i_last=1.
- i_sbox_sel  input  3  S-box index (round mod 8).
- i_last  input  1  final round: apply post-key; downstream bypasses the linear transform.
- o_valid  output  1  output beat valid.
- i_ready  input  1  downstream accepts.
- o_word_0..o_word_3  output  32 each  substituted state.
- o_last  output  1  i_last carried with the beat.

Behaviour:
- Reset (asynchronous, i_rst_n=0):
  - o_valid=0, o_ready=1, o_last=0, o_word_*=0.
  - Skid entry is cleared.
  - Any in-flight beat is discarded.
- Datapath, for bit j in 0..31:
  - n = {w3[j], w2[j], w1[j], w0[j]}, where w_k = i_word_k ^ i_key_k.
  - r = S[sel][n]; output bit j of word k = r[k].
  - If i_last=1, each output word is additionally XORed with i_key_post_k.
- S-box tables, entries for n = 0..15:
  - S0: 3 8 15 1 10 6 5 11 14 13 4 2 7 0 9 12
  - S1: 15 12 2 7 9 0 5 10 1 11 14 8 6 13 3 4
  - S2: 8 6 7 9 3 12 10 15 13 1 14 4 0 11 5 2
  - S3: 0 15 11 8 12 9 6 3 13 1 2 4 10 7 5 14
  - S4: 1 15 8 3 12 0 11 6 2 5 4 10 9 14 7 13
  - S5: 15 5 2 11 4 10 9 12 0 3 14 8 13 6 7 1
  - S6: 7 2 12 5 8 4 6 11 14 9 1 15 13 3 10 0
  - S7: 1 13 15 0 14 8 2 11 7 4 12 10 9 3 5 6
- Handshake:
  - Input transfer occurs when i_valid & o_ready.
  - Output transfer occurs when o_valid & i_ready.
  - Inputs are sampled only on an input transfer.
- Latency and throughput:
  - One cycle: a beat accepted at edge t is visible on the outputs after edge t (o_valid=1 in cycle t+1).
  - Sustained 1 beat/cycle while i_ready=1.
- States, by occupancy:
  - EMPTY: o_valid=0, skid empty.
  - ONE: output register valid, skid empty.
  - FULL: output register and skid both valid.
  - o_ready = (state != FULL), registered.
- Transitions:
  - EMPTY, input transfer → ONE.
  - ONE, input transfer without output transfer → FULL; the new beat goes to skid.
  - ONE, input and output transfer → ONE; the output register takes the new beat.
  - ONE, output transfer only → EMPTY.
  - FULL, output transfer → ONE; skid moves to the output register, skid is freed, o_ready goes to 1.
  - FULL never takes an input transfer, since o_ready=0.
- Output stability: o_word_*/o_last hold stable while o_valid=1 and i_ready=0.
- Ordering: beats leave strictly in acceptance order; no beat is lost or duplicated.
- i_sbox_sel and i_last are captured per beat. Changing them between beats takes effect only for the beat they accompany.
- Reset mid-operation (either occupied state) returns the stage to EMPTY immediately.
- No X propagation: when o_valid=0, o_word_* hold their last value (0 after reset).

Test Plan:
- Zero state, zero key, sel=0, i_last=0 → one cycle later o_valid=1, o_word_0=o_word_1=FFFFFFFF, o_word_2=o_word_3=00000000.
- i_word_0=FFFFFFFF, other words 0, key 0, sel=1 → o_word_2=o_word_3=FFFFFFFF, o_word_0=o_word_1=0.
- State 0, i_key_0=FFFFFFFF, sel=0 → nibble 1 → S0=8 → o_word_3=FFFFFFFF, others 0. Repeat with i_last=1 and i_key_post_3=FFFFFFFF → all four outputs 0, o_last=1.
- Back-pressure:
  - Stream beats A,B,C with i_ready=0 → A in output, B in skid, o_ready=0, C held off.
  - Raise i_ready → A, B, C emerge in order with no gaps or duplicates.
- Full-rate stream of 8 beats, sel=0..7, i_ready=1 → 8 consecutive o_valid cycles, each matching the software S-box model.
- Assert i_rst_n=0 while FULL → o_valid=0, o_ready=1 and o_word_*=0 asynchronously; the next accepted beat is output correctly after one cycle.
